// File: rtl/jstk_txn_scheduler.sv
// Shares the PmodJSTK SPI transaction engine between a periodic position poll and an external command port.
// Optional build macro JSTK_TXN_SCHEDULER_OVERRUN_EN enables the saturating missed-poll counter on overrun_o.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no transaction in flight; arbitrate poll vs. command
// ISSUE | txn_valid_o asserted, holding txn_data_o until engine ready
// WAIT  | engine busy; capture response on txn_done_i
// GAP   | forced idle time before the next grant
module jstk_txn_scheduler #(
  parameter int unsigned  poll_period_p = 12000,
  parameter int unsigned  gap_cycles_p  = 12,
  parameter logic [39:0]  poll_cmd_p    = 40'h00_0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [39:0] cmd_data_i,
  output logic        txn_valid_o,
  input  logic        txn_ready_i,
  output logic [39:0] txn_data_o,
  input  logic        txn_done_i,
  input  logic [39:0] txn_rsp_i,
  output logic [9:0]  pos_x_o,
  output logic [9:0]  pos_y_o,
  output logic [1:0]  buttons_o,
  output logic        pos_valid_o,
  output logic        busy_o,
  output logic [7:0]  overrun_o
);

  localparam int unsigned        TMR_W     = (poll_period_p > 1) ? $clog2(poll_period_p) : 1;
  localparam logic [TMR_W-1:0]   PERIOD_M1 = TMR_W'(poll_period_p - 1);
  localparam logic [7:0]         GAP_M1    = 8'(gap_cycles_p - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_GAP} state_e;

  state_e           state_q, state_d;
  logic [39:0]      data_q, data_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             pending_q, pending_d;
  logic             last_cmd_q, last_cmd_d;
  logic [7:0]       gap_q, gap_d;
  logic [9:0]       pos_x_q, pos_x_d;
  logic [9:0]       pos_y_q, pos_y_d;
  logic [1:0]       buttons_q, buttons_d;
  logic             pos_valid_q, pos_valid_d;

  logic             wrap;
  logic             grant_poll;
  logic             grant_cmd;
  logic             rsp_unused;

  assign rsp_unused = ^{txn_rsp_i[31:26], txn_rsp_i[15:10], txn_rsp_i[7:2]};

  assign wrap      = (timer_q == PERIOD_M1);
  assign timer_d   = wrap ? '0 : timer_q + TMR_W'(1);
  assign pending_d = wrap | (pending_q & ~grant_poll);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      data_q      <= '0;
      timer_q     <= '0;
      pending_q   <= 1'b0;
      last_cmd_q  <= 1'b1;
      gap_q       <= '0;
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      buttons_q   <= '0;
      pos_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      timer_q     <= timer_d;
      pending_q   <= pending_d;
      last_cmd_q  <= last_cmd_d;
      gap_q       <= gap_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      buttons_q   <= buttons_d;
      pos_valid_q <= pos_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    last_cmd_d  = last_cmd_q;
    gap_d       = gap_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    buttons_d   = buttons_q;
    pos_valid_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_poll) begin
          data_d     = poll_cmd_p;
          last_cmd_d = 1'b0;
          state_d    = ST_ISSUE;
        end else if (grant_cmd) begin
          data_d     = cmd_data_i;
          last_cmd_d = 1'b1;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (txn_ready_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (txn_done_i) begin
          pos_x_d     = {txn_rsp_i[9:8], txn_rsp_i[23:16]};
          pos_y_d     = {txn_rsp_i[25:24], txn_rsp_i[39:32]};
          buttons_d   = txn_rsp_i[1:0];
          pos_valid_d = 1'b1;
          gap_d       = GAP_M1;
          state_d     = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == 8'd0) state_d = ST_IDLE;
        else               gap_d   = gap_q - 8'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Round-robin on a tie: last_cmd_q set means the poll goes first.
  always_comb begin
    grant_poll  = 1'b0;
    grant_cmd   = 1'b0;
    txn_valid_o = 1'b0;
    busy_o      = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (pending_q && cmd_valid_i) begin
          grant_poll = last_cmd_q;
          grant_cmd  = ~last_cmd_q;
        end else begin
          grant_poll = pending_q;
          grant_cmd  = cmd_valid_i;
        end
      end
      ST_ISSUE: txn_valid_o = 1'b1;
      default:  ;
    endcase
    cmd_ready_o = grant_cmd;
  end

  assign txn_data_o  = data_q;
  assign pos_x_o     = pos_x_q;
  assign pos_y_o     = pos_y_q;
  assign buttons_o   = buttons_q;
  assign pos_valid_o = pos_valid_q;

`ifdef JSTK_TXN_SCHEDULER_OVERRUN_EN
  logic [7:0] overrun_q, overrun_d;

  assign overrun_d = (wrap && pending_q && (overrun_q != 8'hFF)) ? overrun_q + 8'd1 : overrun_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) overrun_q <= '0;
    else            overrun_q <= overrun_d;
  end

  assign overrun_o = overrun_q;
`else
  assign overrun_o = '0;
`endif

endmodule

// File: tb/tb_jstk_txn_scheduler.sv
// Scoreboard bench for jstk_txn_scheduler (poll period 16, gap 4).
// Expected transmit words and decoded positions are queued as stimulus is driven.
module tb_jstk_txn_scheduler;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [39:0] cmd_data_i;
  logic        txn_valid_o;
  logic        txn_ready_i;
  logic [39:0] txn_data_o;
  logic        txn_done_i;
  logic [39:0] txn_rsp_i;
  logic [9:0]  pos_x_o;
  logic [9:0]  pos_y_o;
  logic [1:0]  buttons_o;
  logic        pos_valid_o;
  logic        busy_o;
  logic [7:0]  overrun_o;

  always #5 clk_i = ~clk_i;

  jstk_txn_scheduler #(
    .poll_period_p (16),
    .gap_cycles_p  (4),
    .poll_cmd_p    (40'h00_0000_0000)
  ) dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_data_i  (cmd_data_i),
    .txn_valid_o (txn_valid_o),
    .txn_ready_i (txn_ready_i),
    .txn_data_o  (txn_data_o),
    .txn_done_i  (txn_done_i),
    .txn_rsp_i   (txn_rsp_i),
    .pos_x_o     (pos_x_o),
    .pos_y_o     (pos_y_o),
    .buttons_o   (buttons_o),
    .pos_valid_o (pos_valid_o),
    .busy_o      (busy_o),
    .overrun_o   (overrun_o)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] b;
  } pos_t;

  int          total = 0;
  int          bad   = 0;
  int          pv_cnt = 0;
  int          acc_cnt = 0;
  logic [39:0] txn_exp_q[$];
  pos_t        pos_exp_q[$];
  pos_t        mon_exp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic pos_t decode(input logic [39:0] r);
    pos_t p;
    p.x = {r[9:8], r[23:16]};
    p.y = {r[25:24], r[39:32]};
    p.b = r[1:0];
    return p;
  endfunction

  always @(negedge clk_i) begin
    if (pos_valid_o) begin
      pv_cnt++;
      if (pos_exp_q.size() == 0) begin
        check("pos_valid_unexpected", 1, 0);
      end else begin
        mon_exp = pos_exp_q.pop_front();
        check("pos_x", pos_x_o, mon_exp.x);
        check("pos_y", pos_y_o, mon_exp.y);
        check("buttons", buttons_o, mon_exp.b);
      end
    end
    if (cmd_ready_o) acc_cnt++;
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset(input bit chk);
    reset_n_i   = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_data_i  = '0;
    txn_ready_i = 1'b0;
    txn_done_i  = 1'b0;
    txn_rsp_i   = '0;
    repeat (3) step();
    if (chk) begin
      check("rst_txn_valid", txn_valid_o, 0);
      check("rst_cmd_ready", cmd_ready_o, 0);
      check("rst_txn_data", txn_data_o, 0);
      check("rst_pos_x", pos_x_o, 0);
      check("rst_pos_y", pos_y_o, 0);
      check("rst_buttons", buttons_o, 0);
      check("rst_pos_valid", pos_valid_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_overrun", overrun_o, 0);
    end
    reset_n_i = 1'b1;
  endtask

  task automatic serve(input int rdy_dly, input int done_dly, input logic [39:0] rsp);
    int          n = 0;
    logic [39:0] d0;
    logic [39:0] e;
    while (!txn_valid_o && n < 200) begin
      step();
      n++;
    end
    check("txn_valid_wait", txn_valid_o, 1);
    d0 = txn_data_o;
    if (txn_exp_q.size() == 0) begin
      check("txn_exp_empty", 1, 0);
    end else begin
      e = txn_exp_q.pop_front();
      check("txn_data", d0, e);
    end
    for (int i = 0; i < rdy_dly; i++) begin
      step();
      check("stall_valid", txn_valid_o, 1);
      check("stall_data", txn_data_o, d0);
    end
    txn_ready_i = 1'b1;
    step();
    txn_ready_i = 1'b0;
    check("valid_drop", txn_valid_o, 0);
    for (int i = 1; i < done_dly; i++) step();
    txn_rsp_i  = rsp;
    txn_done_i = 1'b1;
    pos_exp_q.push_back(decode(rsp));
    step();
    txn_done_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: time limit reached, got running want finished");
    $fatal(1, "time limit");
  end

  initial begin
    int          n;
    int          acc0;
    logic [63:0] r;
    logic [7:0]  ov_mid;
    logic [7:0]  ov_end;

`ifdef JSTK_TXN_SCHEDULER_OVERRUN_EN
    ov_mid = 8'd1;
    ov_end = 8'd2;
`else
    ov_mid = 8'd0;
    ov_end = 8'd0;
`endif

    // poll only, then spurious done in IDLE
    do_reset(1'b1);
    txn_exp_q.push_back(40'h0);
    n = 0;
    while (!txn_valid_o && n < 100) begin
      step();
      n++;
    end
    check("first_valid_cycle", n, 17);
    serve(0, 3, 40'hA5_02_7F_01_03);
    repeat (3) step();
    check("busy_gap_end", busy_o, 1);
    step();
    check("busy_idle", busy_o, 0);
    check("poll_pos_x", pos_x_o, 10'h17F);
    check("poll_pos_y", pos_y_o, 10'h2A5);
    check("poll_buttons", buttons_o, 2'b11);
    check("poll_pv_count", pv_cnt, 1);
    txn_rsp_i  = 40'hFF_FFFF_FFFF;
    txn_done_i = 1'b1;
    step();
    txn_done_i = 1'b0;
    check("spur_pos_x", pos_x_o, 10'h17F);
    check("spur_pos_y", pos_y_o, 10'h2A5);
    check("spur_buttons", buttons_o, 2'b11);
    check("spur_pos_valid", pos_valid_o, 0);
    check("spur_busy", busy_o, 0);
    step();
    check("spur_pv_count", pv_cnt, 1);

    // tie: poll wins first, command next
    do_reset(1'b0);
    acc0 = acc_cnt;
    repeat (16) step();
    check("tie_idle", busy_o, 0);
    cmd_valid_i = 1'b1;
    cmd_data_i  = 40'h84_FF00_0000;
    #1;
    check("tie_cmd_ready", cmd_ready_o, 0);
    txn_exp_q.push_back(40'h0);
    txn_exp_q.push_back(40'h84_FF00_0000);
    r = {$urandom, $urandom};
    serve(0, 3, r[39:0]);
    n = 0;
    while (!cmd_ready_o && n < 20) begin
      step();
      n++;
    end
    check("cmd_grant_delay", n, 4);
    step();
    cmd_valid_i = 1'b0;
    r = {$urandom, $urandom};
    serve(0, 3, r[39:0]);
    step();
    check("cmd_ready_pulses", acc_cnt - acc0, 1);
    check("tie_sb_empty", pos_exp_q.size(), 0);

    // backpressure with a command waiting
    do_reset(1'b0);
    acc0 = acc_cnt;
    txn_exp_q.push_back(40'h0);
    repeat (17) step();
    check("bp_valid", txn_valid_o, 1);
    cmd_valid_i = 1'b1;
    cmd_data_i  = 40'h12_3456_789A;
    r = {$urandom, $urandom};
    serve(10, 3, r[39:0]);
    cmd_valid_i = 1'b0;
    check("bp_no_grant", acc_cnt - acc0, 0);
    repeat (6) step();
    check("bp_cmd_dropped", acc_cnt - acc0, 0);
    check("bp_sb_empty", pos_exp_q.size(), 0);

    // long stall: missed polls
    do_reset(1'b0);
    txn_exp_q.push_back(40'h0);
    r = {$urandom, $urandom};
    serve(40, 3, r[39:0]);
    check("overrun_mid", overrun_o, ov_mid);
    repeat (6) step();
    check("overrun_end", overrun_o, ov_end);
    check("ov_sb_empty", pos_exp_q.size(), 0);

    // reset while waiting for the engine
    do_reset(1'b0);
    txn_exp_q.push_back(40'h0);
    serve(0, 3, 40'h3C_01_5A_02_02);
    txn_exp_q.push_back(40'h0);
    n = 0;
    while (!txn_valid_o && n < 50) begin
      step();
      n++;
    end
    check("rw_second_poll", n, 12);
    check("rw_txn_data", txn_data_o, txn_exp_q.pop_front());
    check("rw_pos_x_before", pos_x_o, 10'h25A);
    txn_ready_i = 1'b1;
    step();
    txn_ready_i = 1'b0;
    step();
    check("rw_busy_before", busy_o, 1);
    reset_n_i = 1'b0;
    #1;
    check("rw_pos_x", pos_x_o, 0);
    check("rw_pos_y", pos_y_o, 0);
    check("rw_buttons", buttons_o, 0);
    check("rw_busy", busy_o, 0);
    check("rw_txn_valid", txn_valid_o, 0);
    check("rw_txn_data_rst", txn_data_o, 0);
    step();
    step();
    reset_n_i = 1'b1;
    step();
    txn_rsp_i  = 40'hFF_FFFF_FFFF;
    txn_done_i = 1'b1;
    step();
    txn_done_i = 1'b0;
    check("late_pos_x", pos_x_o, 0);
    check("late_pos_y", pos_y_o, 0);
    check("late_buttons", buttons_o, 0);
    check("late_pos_valid", pos_valid_o, 0);
    check("late_busy", busy_o, 0);
    repeat (2) step();
    check("late_hold_x", pos_x_o, 0);
    check("late_hold_busy", busy_o, 0);

    check("sb_drain", pos_exp_q.size(), 0);
    check("txn_q_drain", txn_exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jstk_txn_scheduler.md
Name: jstk_txn_scheduler

Overview:
- Sequences and shares the single joystick SPI transaction engine (the 40-bit PmodJSTK exchange) between two requesters.
- Requester 1 is an internal periodic position poll. Requester 2 is an external command port, e.g. LED colour writes from game logic.
- Issues one transaction at a time, enforces an inter-transaction gap, decodes every response into registered X/Y position and button outputs.
- Sits between the top-level game logic and the PmodJSTK driver.

Parameters:
- poll_period_p, 12000, cycles between poll requests (1 ms at 12 MHz); legal range 2..2^20.
- gap_cycles_p, 12, idle cycles forced after each transaction completes; legal range 1..255.
- poll_cmd_p, 40'h00_0000_0000, transmit word used for poll transactions.

Ports:
- clk_i  in  1  single clock domain.
- reset_n_i  in  1  asynchronous, active-low reset.
- cmd_valid_i  in  1  external command request.
- cmd_ready_o  out  1  command accepted this cycle.
- cmd_data_i  in  40  external command transmit word.
- txn_valid_o  out  1  transaction request to SPI engine.
- txn_ready_i  in  1  engine accepts request.
- txn_data_o  out  40  transmit word to engine.
- txn_done_i  in  1  one-cycle pulse, response valid.
- txn_rsp_i  in  40  response word, valid with txn_done_i.
- pos_x_o  out  10  {rsp[9:8], rsp[23:16]}.
- pos_y_o  out  10  {rsp[25:24], rsp[39:32]}.
- buttons_o  out  2  rsp[1:0].
- pos_valid_o  out  1  one-cycle pulse, position outputs updated.
- busy_o  out  1  high in any state except IDLE.
- overrun_o  out  8  missed-poll count (see Optional Feature).

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE.
  - All outputs = 0; txn_data_o = 0.
  - Poll timer = 0; poll_pending = 0; last_grant = CMD, so poll wins the first tie.
- Poll timer:
  - Free-runs 0..poll_period_p-1, then wraps.
  - On the wrap cycle sets poll_pending.
  - First poll_pending occurs poll_period_p cycles after reset release.
  - poll_pending clears when a poll is granted.
  - If poll_pending is already set at a wrap, the request is not queued; it counts as an overrun.
- FSM states: IDLE, ISSUE, WAIT, GAP.
  - IDLE:
    - Grant when poll_pending or cmd_valid_i.
    - Both pending: grant the requester not granted last (round-robin).
    - Cmd grant: cmd_ready_o = 1 combinationally that cycle and cmd_data_i is captured.
    - Poll grant: poll_cmd_p is captured.
    - On any grant, go to ISSUE next cycle; last_grant is updated.
    - cmd_ready_o is 0 in every other state and in IDLE when poll is granted.
  - ISSUE:
    - txn_valid_o = 1; txn_data_o holds stable.
    - Stays in ISSUE until txn_ready_i = 1, then goes to WAIT.
    - txn_valid_o deasserts on the following cycle.
  - WAIT:
    - On txn_done_i, register pos_x_o / pos_y_o / buttons_o from txn_rsp_i.
    - pos_valid_o = 1 for exactly one cycle, the cycle after txn_done_i.
    - Go to GAP.
    - Applies to both poll and cmd responses.
  - GAP:
    - Counts gap_cycles_p cycles, then returns to IDLE.
    - Requests arriving during GAP wait for IDLE.
- txn_done_i outside WAIT is ignored; outputs are unchanged.
- Minimum grant-to-grant spacing: 1 (IDLE) + 1 (ISSUE, ready immediate) + WAIT duration + gap_cycles_p.
- Position outputs hold their last value between updates; they are not cleared except by reset.
- Reset mid-transaction:
  - Abandon immediately and return to IDLE with outputs = 0.
  - A late txn_done_i after release is ignored by the IDLE rule above.
- cmd_valid_i may drop without acceptance; no state change results.

Optional Feature:
- Macro: JSTK_TXN_SCHEDULER_OVERRUN_EN.
- Defined:
  - overrun_o is an 8-bit saturating counter, incremented when the poll timer wraps while poll_pending = 1.
  - Holds at 255; reset to 0 only by reset_n_i.
- Undefined:
  - overrun_o tied to 0; no counter logic.
  - The port always exists so the interface is identical in both builds.

Test Plan:
- Test parameters: poll_period_p = 16, gap_cycles_p = 4.
- Poll only: engine ready immediately, done 3 cycles after ready, rsp = 40'hA5_02_7F_01_03.
  - First txn_valid_o at cycle 17 after release.
  - txn_data_o = 0.
  - pos_x_o = 10'h17F, pos_y_o = 10'h2A5, buttons_o = 2'b11.
  - pos_valid_o pulses once.
- Tie: cmd_valid_i held with data 40'h84_FF00_0000 when poll_pending rises.
  - Poll is granted first; cmd_ready_o = 0.
  - Next grant goes to cmd; cmd_ready_o is a single-cycle pulse; txn_data_o = 40'h84FF000000.
- Backpressure: txn_ready_i held low 10 cycles.
  - txn_valid_o stays high 10 cycles.
  - txn_data_o is stable.
  - No second grant.
- Overrun: txn_ready_i held low 40 cycles.
  - With macro defined, overrun_o = 2.
  - Without macro, overrun_o = 0.
- Reset during WAIT: assert reset_n_i low mid-transaction, release, then pulse txn_done_i.
  - Outputs are 0 and stay 0.
  - No pos_valid_o.
  - busy_o = 0.
- Spurious done: txn_done_i pulsed in IDLE with rsp = 40'hFFFFFFFFFF.
  - Position outputs unchanged.
  - pos_valid_o = 0.
